// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared constants and types for the instruction fetch / prefetch queue.
package fetch_prefetch_queue_pkg;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_STEP = 4;
    localparam int unsigned Q_DEPTH = 4;

    localparam logic [ADDR_W-1:0] RESET_PC = 64'h0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// DEPTH-entry FIFO of {pc, word} with flush; full/empty decided by the occupancy count.
module fetch_queue_fifo
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = Q_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  fetch_entry_t           push_data_i,
    input  logic                   pop_i,
    output fetch_entry_t           head_o,
    output logic                   valid_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_c, do_pop_c;

    always_comb begin
        do_push_c = push_i && (count_q != CNT_W'(DEPTH));
        do_pop_c  = pop_i && (count_q != '0);
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push_c, do_pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (!flush_i && do_push_c) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign valid_o = (count_q != '0);
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch stage: issues sequential ROM reads under credit control and queues returned words with their PC.
module fetch_prefetch_queue
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = Q_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [ADDR_W-1:0]      rom_addr_o,
    output logic                   rom_en_c_o,
    input  logic [INSTR_W-1:0]     rom_data_i,
    input  logic                   redirect_valid_i,
    input  logic [ADDR_W-1:0]      redirect_pc_i,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic [INSTR_W-1:0]     instr_word_o,
    output logic [ADDR_W-1:0]      instr_pc_o,
    output logic [$clog2(DEPTH):0] queue_count_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;

    logic [CNT_W-1:0]  count;
    logic              fifo_valid;
    fetch_entry_t      push_entry_c, head_entry;
    logic [OCC_W-1:0]  occ_now_c, occ_next_c;
    logic              has_credit_c, issue_c, push_c, pop_c;

    // Credit = DEPTH minus (queued + in-flight); a redirect, reset or FLUSH suppresses issue.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;

        occ_now_c    = OCC_W'(count) + OCC_W'(inflight_q);
        has_credit_c = occ_now_c < OCC_W'(DEPTH);
        issue_c      = (state_q != FLUSH) && has_credit_c && !redirect_valid_i && !rst;
        push_c       = inflight_q && !redirect_valid_i;
        pop_c        = fifo_valid && instr_ready_i && !redirect_valid_i;
        occ_next_c   = OCC_W'(count) + OCC_W'(push_c) - OCC_W'(pop_c) + OCC_W'(issue_c);

        if (redirect_valid_i) begin
            state_d    = FLUSH;
            fetch_pc_d = redirect_pc_i;
            inflight_d = 1'b0;
        end else begin
            inflight_d = issue_c;
            if (issue_c) begin
                fetch_pc_d    = fetch_pc_q + ADDR_W'(PC_STEP);
                inflight_pc_d = fetch_pc_q;
            end
            case (state_q)
                RUN:     if (occ_next_c == OCC_W'(DEPTH)) state_d = STALL;
                STALL:   if (pop_c) state_d = RUN;
                FLUSH:   state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign push_entry_c = '{pc: inflight_pc_q, word: rom_data_i};

    fetch_queue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid_i),
        .push_i      (push_c),
        .push_data_i (push_entry_c),
        .pop_i       (pop_c),
        .head_o      (head_entry),
        .valid_o     (fifo_valid),
        .count_o     (count)
    );

    assign rom_addr_o    = fetch_pc_q;
    assign rom_en_c_o    = issue_c;
    assign instr_valid_o = fifo_valid;
    assign instr_word_o  = head_entry.word;
    assign instr_pc_o    = head_entry.pc;
    assign queue_count_o = count;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: cycle vectors plus redirect/wrap/reset sequences, with a PC scoreboard.
module tb_fetch_prefetch_queue;
    import fetch_prefetch_queue_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [ADDR_W-1:0]  rom_addr;
    logic               rom_en;
    logic [INSTR_W-1:0] rom_data = '0;
    logic               redirect_valid = 1'b0;
    logic [ADDR_W-1:0]  redirect_pc = '0;
    logic               instr_valid;
    logic               instr_ready = 1'b1;
    logic [INSTR_W-1:0] instr_word;
    logic [ADDR_W-1:0]  instr_pc;
    logic [2:0]         queue_count;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fetch_prefetch_queue #(.DEPTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .rom_addr_o       (rom_addr),
        .rom_en_c_o       (rom_en),
        .rom_data_i       (rom_data),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .instr_valid_o    (instr_valid),
        .instr_ready_i    (instr_ready),
        .instr_word_o     (instr_word),
        .instr_pc_o       (instr_pc),
        .queue_count_o    (queue_count)
    );

    // One-cycle ROM whose contents are addr>>2; a junk word when not read.
    always @(posedge clk) rom_data <= rom_en ? 32'(rom_addr >> 2) : 32'hBADC_0DE5;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: expected PCs queued per issued read, dropped on redirect/reset.
    logic [ADDR_W-1:0] sb_q[$];
    logic [ADDR_W-1:0] model_pc = '0;

    always @(posedge clk) begin : mon
        logic [ADDR_W-1:0] exp_pc;
        check("inv.valid_vs_count", 64'(instr_valid), 64'(queue_count != 3'd0));
        if (rst || redirect_valid) begin
            check("inv.no_issue_rst_redirect", 64'(rom_en), 64'd0);
            sb_q.delete();
            model_pc = rst ? RESET_PC : redirect_pc;
        end else begin
            if (instr_valid && instr_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb.unexpected_word_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_pc = sb_q.pop_front();
                    check("sb.pc", instr_pc, exp_pc);
                    check("sb.word", 64'(instr_word), 64'(32'(exp_pc >> 2)));
                end
            end
            if (rom_en) begin
                check("sb.rom_addr", rom_addr, model_pc);
                sb_q.push_back(model_pc);
                model_pc = model_pc + 64'(PC_STEP);
            end
        end
    end

    typedef struct {
        logic        rst;
        logic        ready;
        logic        chk;
        logic [2:0]  cnt;
        logic        valid;
        logic        en;
        logic [63:0] addr;
        logic [63:0] pc;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic r, input logic rdy, input logic c, input int cnt,
                                input logic v, input logic e, input logic [63:0] a, input logic [63:0] p);
        vec_t t;
        t.rst = r; t.ready = rdy; t.chk = c; t.cnt = 3'(cnt);
        t.valid = v; t.en = e; t.addr = a; t.pc = p;
        return t;
    endfunction

    task automatic wait_valid(input string name, input int max_cycles);
        int n = 0;
        while (!instr_valid && n < max_cycles) begin
            @(negedge clk); #1;
            n++;
        end
        check({name, ".valid_within_bound"}, 64'(instr_valid), 64'd1);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Streaming with ready held, then a fresh reset with ready low to fill and drain.
        vecs[0]  = mk(1, 1, 0, 0, 0, 0, 0,  0);
        vecs[1]  = mk(1, 1, 1, 0, 0, 0, 0,  0);
        vecs[2]  = mk(0, 1, 1, 0, 0, 1, 0,  0);
        vecs[3]  = mk(0, 1, 1, 0, 0, 1, 4,  0);
        vecs[4]  = mk(0, 1, 1, 1, 1, 1, 8,  0);
        vecs[5]  = mk(0, 1, 1, 1, 1, 1, 12, 4);
        vecs[6]  = mk(0, 1, 1, 1, 1, 1, 16, 8);
        vecs[7]  = mk(1, 0, 1, 1, 1, 0, 0,  12);
        vecs[8]  = mk(0, 0, 1, 0, 0, 1, 0,  0);
        vecs[9]  = mk(0, 0, 1, 0, 0, 1, 4,  0);
        vecs[10] = mk(0, 0, 1, 1, 1, 1, 8,  0);
        vecs[11] = mk(0, 0, 1, 2, 1, 1, 12, 0);
        vecs[12] = mk(0, 0, 1, 3, 1, 0, 16, 0);
        for (int i = 13; i < 18; i++) vecs[i] = mk(0, 0, 1, 4, 1, 0, 16, 0);
        vecs[18] = mk(0, 1, 1, 4, 1, 0, 16, 0);
        vecs[19] = mk(0, 1, 1, 3, 1, 1, 16, 4);
        vecs[20] = mk(0, 1, 1, 2, 1, 1, 20, 8);
        vecs[21] = mk(0, 1, 1, 2, 1, 1, 24, 12);
        vecs[22] = mk(0, 1, 1, 2, 1, 1, 28, 16);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            instr_ready = vecs[i].ready;
            redirect_valid = 1'b0;
            #1;
            if (vecs[i].chk) begin
                check($sformatf("v%0d.count", i), 64'(queue_count), 64'(vecs[i].cnt));
                check($sformatf("v%0d.valid", i), 64'(instr_valid), 64'(vecs[i].valid));
                check($sformatf("v%0d.rom_en", i), 64'(rom_en), 64'(vecs[i].en));
                if (vecs[i].en) check($sformatf("v%0d.rom_addr", i), rom_addr, vecs[i].addr);
                check($sformatf("v%0d.pc", i), instr_pc, vecs[i].valid ? vecs[i].pc : 64'd0);
                check($sformatf("v%0d.word", i), 64'(instr_word),
                      vecs[i].valid ? 64'(32'(vecs[i].pc >> 2)) : 64'd0);
            end
        end

        // Redirect with three words queued and one read in flight.
        @(negedge clk); rst = 1'b1; instr_ready = 1'b0;
        @(negedge clk); rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("redir.count_before", 64'(queue_count), 64'd3);
        redirect_valid = 1'b1; redirect_pc = 64'h100;
        #1;
        check("redir.rom_en_in_redirect", 64'(rom_en), 64'd0);
        @(negedge clk); redirect_valid = 1'b0; instr_ready = 1'b1;
        #1;
        check("redir.count_after", 64'(queue_count), 64'd0);
        check("redir.valid_after", 64'(instr_valid), 64'd0);
        check("redir.rom_en_flush", 64'(rom_en), 64'd0);
        @(negedge clk); #1;
        check("redir.rom_en_resume", 64'(rom_en), 64'd1);
        check("redir.rom_addr_resume", rom_addr, 64'h100);
        wait_valid("redir", 8);
        check("redir.first_pc", instr_pc, 64'h100);
        check("redir.first_word", 64'(instr_word), 64'h40);

        // Back-to-back redirects: the later target wins.
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 64'h200;
        @(negedge clk); redirect_pc = 64'h300;
        @(negedge clk); redirect_valid = 1'b0;
        #1;
        wait_valid("b2b", 8);
        check("b2b.first_pc", instr_pc, 64'h300);
        check("b2b.first_word", 64'(instr_word), 64'hC0);

        // Fetch address wraps past the top of the address space.
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk); redirect_valid = 1'b0;
        #1;
        check("wrap.rom_en_flush", 64'(rom_en), 64'd0);
        @(negedge clk); #1;
        check("wrap.addr_top", rom_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap.en_top", 64'(rom_en), 64'd1);
        @(negedge clk); #1;
        check("wrap.addr_zero", rom_addr, 64'h0);
        check("wrap.en_zero", 64'(rom_en), 64'd1);

        // Reset with a full queue and a simultaneous redirect.
        @(negedge clk); instr_ready = 1'b0;
        #1;
        n = 0;
        while (queue_count != 3'd4 && n < 12) begin
            @(negedge clk); #1;
            n++;
        end
        check("rstmid.full_before", 64'(queue_count), 64'd4);
        @(negedge clk); rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h500;
        #1;
        check("rstmid.rom_en_in_reset", 64'(rom_en), 64'd0);
        @(negedge clk); redirect_valid = 1'b0;
        #1;
        check("rstmid.count", 64'(queue_count), 64'd0);
        check("rstmid.valid", 64'(instr_valid), 64'd0);
        check("rstmid.rom_en", 64'(rom_en), 64'd0);
        check("rstmid.pc_zero", instr_pc, 64'd0);
        check("rstmid.word_zero", 64'(instr_word), 64'd0);
        @(negedge clk); rst = 1'b0; instr_ready = 1'b1;
        #1;
        check("rstmid.resume_en", 64'(rom_en), 64'd1);
        check("rstmid.resume_addr", rom_addr, RESET_PC);
        wait_valid("rstmid", 8);
        check("rstmid.first_pc", instr_pc, RESET_PC);
        check("rstmid.first_word", 64'(instr_word), 64'd0);

        repeat (8) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
